ck_sleep_ctrl: RTL
==================

CK_SLEEP_CTRL -- requirements
Module: ck_sleep_ctrl

Interface
REQ-001 Parameter DMP_IDLE_CYCLES, default 4: consecutive DMP-idle cycles required before ck_dmp_gated asserts; legal range 1..15.
REQ-002 Parameter CNT_W, default 16: width of the gated-cycle statistics counter.
REQ-003 Port clk_ungated, input, 1: the single clock, never gated; all flops are on its rising edge.
REQ-004 Port rst_a, input, 1: synchronous active-high reset.
REQ-005 Port halt_r, input, 1: core halted.
REQ-006 Port sleeping, input, 1: core executing SLEEP.
REQ-007 Port ld_pending, input, 1: load outstanding.
REQ-008 Port mem_busy, input, 1: main memory access in progress.
REQ-009 Port host_busy, input, 1: host access in progress.
REQ-010 Port irq_pending, input, 1: any interrupt request.
REQ-011 Port idle_thresh, input, 4: core-idle hysteresis in cycles, from aux register.
REQ-012 Port dmp_busy, input, 1: DMP operation in flight.
REQ-013 Port dmp_req, input, 1: level request to the DMP, held by the requester until accepted.
REQ-014 Port gated_cnt_clr, input, 1: clear the statistics counter.
REQ-015 Port ck_disable, output, 1: registered; 1 gates the main and DMP clocks.
REQ-016 Port ck_dmp_gated, output, 1: registered; 1 gates the DMP clock only.
REQ-017 Port ck_state, output, 2: current FSM state.
REQ-018 Port gated_cnt, output, CNT_W: count of cycles with ck_disable=1.

Function
REQ-019 idle = (halt_r | sleeping) & ~ld_pending & ~mem_busy & ~host_busy & ~irq_pending; wake = ~idle.
REQ-020 FSM states are RUN=0, COUNT=1 and GATED=2; encoding 3 is illegal and returns to RUN on the next cycle.
REQ-021 RUN: on idle with idle_thresh=0, go to GATED; on idle with idle_thresh>0, go to COUNT and load the timer with idle_thresh; otherwise stay in RUN.
REQ-022 COUNT: on wake, go to RUN; on idle with timer=1, go to GATED; otherwise decrement the timer.
REQ-023 GATED: on wake, go to RUN; otherwise stay in GATED.
REQ-024 ck_disable is a flop equal to (next_state==GATED), so gating latency after entry is 0 cycles relative to the state.
REQ-025 A wake event sampled in cycle N gives ck_disable=0 in cycle N+1.
REQ-026 idle_thresh is sampled only when the timer loads; a change during COUNT takes effect on the next load.
REQ-027 DMP timer: on a cycle with ~dmp_busy & ~dmp_req, count up, saturating at DMP_IDLE_CYCLES.
REQ-028 DMP timer: on a cycle with dmp_busy | dmp_req, clear to 0.
REQ-029 ck_dmp_gated is a flop set when the timer reaches DMP_IDLE_CYCLES.
REQ-030 ck_dmp_gated clears in the cycle after dmp_req | dmp_busy is sampled.
REQ-031 ck_dmp_gated is independent of ck_disable.
REQ-032 gated_cnt increments by 1 per cycle with ck_disable=1 and saturates at all-ones with no wrap.
REQ-033 When gated_cnt_clr and an increment occur in the same cycle, the clear wins.

Reset
REQ-034 While rst_a=1 at a clock edge: state=RUN, both timers=0, ck_disable=0, ck_dmp_gated=0, gated_cnt=0.
REQ-035 Reset asserted in GATED or COUNT ungates on the first edge with rst_a=1.
REQ-036 Inputs are ignored during reset.

Configuration
REQ-037 Macro CK_DMP_GATING_EN: when defined, the DMP timer and ck_dmp_gated logic are present.
REQ-038 When CK_DMP_GATING_EN is undefined, ck_dmp_gated is constant 0, dmp_busy and dmp_req are unused, and no DMP timer flops exist.

Structure
REQ-039 The shared package holds the ck_state encodings (RUN/COUNT/GATED) and the idle_thresh width constant.
REQ-040 Sub-module ck_idle_timer is a loadable saturating 4-bit counter with load, dec/inc, and zero/terminal flags, instantiated for both the core and DMP timers.

Verification
REQ-041 Scenario: halt_r=1, other inputs 0, idle_thresh=3 -> COUNT for 3 cycles, then ck_disable=1 on the 4th edge after idle.
REQ-042 Scenario: in GATED, pulse irq_pending for 1 cycle -> ck_disable=0 on the next edge, state=RUN.
REQ-043 Scenario: in COUNT with timer=2, host_busy=1 -> RUN and ck_disable stays 0; re-idle reloads the full threshold.
REQ-044 Scenario: idle_thresh=0 with sleeping=1 -> ck_disable=1 one edge after idle; gated_cnt with CNT_W=4 saturates at 15 after 20 gated cycles; gated_cnt_clr together with an increment -> 0.
REQ-045 Scenario: dmp_busy and dmp_req both 0 for 4 cycles -> ck_dmp_gated=1; dmp_req=1 -> ck_dmp_gated=0 next edge; without CK_DMP_GATING_EN -> ck_dmp_gated stays 0 throughout.
REQ-046 Scenario: rst_a=1 while in GATED with gated_cnt=9 -> next edge gives ck_disable=0, gated_cnt=0, ck_state=0.

Source files
------------

// File: rtl/ck_sleep_ctrl_pkg.sv
// Shared encodings for the clock sleep controller: FSM state values and the
// width of the idle hysteresis threshold.
package ck_sleep_ctrl_pkg;

    localparam int IDLE_THRESH_W = 4;

    typedef enum logic [1:0] {
        CK_RUN   = 2'd0,
        CK_COUNT = 2'd1,
        CK_GATED = 2'd2
    } ck_state_e;

endpackage

// File: rtl/ck_idle_timer.sv
// Loadable 4-bit counter: load has priority, decrement saturates at zero and
// increment saturates at TERM. Flags report zero and terminal count.
module ck_idle_timer
    import ck_sleep_ctrl_pkg::*;
#(
    parameter logic [IDLE_THRESH_W-1:0] TERM = IDLE_THRESH_W'(1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [IDLE_THRESH_W-1:0] load_val,
    input  logic                     dec,
    input  logic                     inc,
    output logic [IDLE_THRESH_W-1:0] cnt,
    output logic                     zero,
    output logic                     term
);

    logic [IDLE_THRESH_W-1:0] cnt_q;
    logic [IDLE_THRESH_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - IDLE_THRESH_W'(1);
        end else if (inc && (cnt_q < TERM)) begin
            cnt_d = cnt_q + IDLE_THRESH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);
    assign term = (cnt_q == TERM);

endmodule

// File: rtl/ck_sleep_ctrl.sv
// Core/DMP clock gating controller with idle hysteresis and a gated-cycle
// statistics counter. DMP gating is built only when CK_DMP_GATING_EN is defined.
module ck_sleep_ctrl
    import ck_sleep_ctrl_pkg::*;
#(
    parameter int DMP_IDLE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic                     clk_ungated,
    input  logic                     rst_a,
    input  logic                     halt_r,
    input  logic                     sleeping,
    input  logic                     ld_pending,
    input  logic                     mem_busy,
    input  logic                     host_busy,
    input  logic                     irq_pending,
    input  logic [IDLE_THRESH_W-1:0] idle_thresh,
    input  logic                     dmp_busy,
    input  logic                     dmp_req,
    input  logic                     gated_cnt_clr,
    output logic                     ck_disable,
    output logic                     ck_dmp_gated,
    output logic [1:0]               ck_state,
    output logic [CNT_W-1:0]         gated_cnt
);

    ck_state_e          state_q, state_d;
    logic               ck_disable_q, ck_disable_d;
    logic [CNT_W-1:0]   gated_cnt_q, gated_cnt_d;
    logic               idle;
    logic               tmr_load, tmr_dec, tmr_zero, tmr_term;
    logic [IDLE_THRESH_W-1:0] unused_core_cnt;

    assign idle = (halt_r | sleeping) & ~ld_pending & ~mem_busy & ~host_busy & ~irq_pending;

    ck_idle_timer #(.TERM(IDLE_THRESH_W'(1))) u_core_timer (
        .clk      (clk_ungated),
        .rst      (rst_a),
        .load     (tmr_load),
        .load_val (idle_thresh),
        .dec      (tmr_dec),
        .inc      (1'b0),
        .cnt      (unused_core_cnt),
        .zero     (tmr_zero),
        .term     (tmr_term)
    );

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        case (state_q)
            CK_RUN: begin
                if (idle) begin
                    if (idle_thresh == '0) begin
                        state_d = CK_GATED;
                    end else begin
                        state_d  = CK_COUNT;
                        tmr_load = 1'b1;
                    end
                end
            end
            CK_COUNT: begin
                // A zero timer is unreachable here; treat it like terminal so COUNT cannot stall.
                if (!idle) begin
                    state_d = CK_RUN;
                end else if (tmr_term || tmr_zero) begin
                    state_d = CK_GATED;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            CK_GATED: begin
                if (!idle) begin
                    state_d = CK_RUN;
                end
            end
            default: state_d = CK_RUN;
        endcase

        ck_disable_d = (state_d == CK_GATED);

        gated_cnt_d = gated_cnt_q;
        if (gated_cnt_clr) begin
            gated_cnt_d = '0;
        end else if (ck_disable_q && (gated_cnt_q != '1)) begin
            gated_cnt_d = gated_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_ungated) begin
        if (rst_a) begin
            state_q      <= CK_RUN;
            ck_disable_q <= 1'b0;
            gated_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            ck_disable_q <= ck_disable_d;
            gated_cnt_q  <= gated_cnt_d;
        end
    end

    assign ck_disable = ck_disable_q;
    assign ck_state   = state_q;
    assign gated_cnt  = gated_cnt_q;

`ifdef CK_DMP_GATING_EN
    localparam logic [IDLE_THRESH_W-1:0] DMP_TERM = IDLE_THRESH_W'(DMP_IDLE_CYCLES);
    localparam logic [IDLE_THRESH_W-1:0] DMP_PRE  = IDLE_THRESH_W'(DMP_IDLE_CYCLES - 1);

    logic                     dmp_quiet;
    logic                     ck_dmp_gated_q, ck_dmp_gated_d;
    logic [IDLE_THRESH_W-1:0] dmp_cnt;
    logic                     dmp_term, unused_dmp_zero;

    assign dmp_quiet = ~dmp_busy & ~dmp_req;

    ck_idle_timer #(.TERM(DMP_TERM)) u_dmp_timer (
        .clk      (clk_ungated),
        .rst      (rst_a),
        .load     (~dmp_quiet),
        .load_val ('0),
        .dec      (1'b0),
        .inc      (dmp_quiet),
        .cnt      (dmp_cnt),
        .zero     (unused_dmp_zero),
        .term     (dmp_term)
    );

    // Gate on the same edge the timer reaches its terminal count.
    always_comb begin
        ck_dmp_gated_d = dmp_quiet & (dmp_term | (dmp_cnt == DMP_PRE));
    end

    always_ff @(posedge clk_ungated) begin
        if (rst_a) begin
            ck_dmp_gated_q <= 1'b0;
        end else begin
            ck_dmp_gated_q <= ck_dmp_gated_d;
        end
    end

    assign ck_dmp_gated = ck_dmp_gated_q;
`else
    logic unused_dmp_in;
    assign unused_dmp_in = dmp_busy ^ dmp_req;
    assign ck_dmp_gated  = 1'b0;
`endif

endmodule
